aes_key_sched: RTL

//  Word-serial AES key schedule for AES-128/192/256, selected per key load; one 32-bit word per cycle.

---
 rtl/aes_key_sched_if.sv | 26 ++
 rtl/aes_key_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: key-load and round-key read bundle for aes_key_sched.
// master drives key/read requests, slave is the key schedule.
interface aes_key_sched_if;
    logic         init_key;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         ready_key;
    logic         key_err;
    logic [3:0]   nr;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_inv;
    logic         rd_valid;
    logic [127:0] rd_key;

    modport master (
        output init_key, key_len, key, rd_en, rd_round, rd_inv,
        input  busy, ready_key, key_err, nr, rd_valid, rd_key
    );

    modport slave (
        input  init_key, key_len, key, rd_en, rd_round, rd_inv,
        output busy, ready_key, key_err, nr, rd_valid, rd_key
    );
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched: word-serial AES-128/192/256 key schedule with a registered round-key port.
// Define AES_KEY_EQINV_EN to add the equivalent-inverse (InvMixColumns) read form.

module aes_sbox (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sub(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] b;
        r = a;
        for (int k = 0; k < 6; k++) r = gmul(gmul(r, r), a);
        b = gmul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int g = 0; g < 4; g++) dout[8*g +: 8] = sub(din[8*g +: 8]);
    end
endmodule

module aes_key_sched #(
    parameter int MAX_NK = 8
) (
    input logic           clk,
    input logic           rst,
    aes_key_sched_if.slave ks
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]    state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [AW-1:0] last_idx;
    logic [2:0]    mod_cnt;
    logic [3:0]    nk;
    logic [7:0]    rcon;
    logic          busy_q;
    logic          ready_q;
    logic          err_q;
    logic [3:0]    nr_q;
    logic          rd_valid_q;
    logic [127:0]  rd_key_q;

    logic [3:0]    load_nk;
    logic          len_ok;
    logic          load;
    logic [31:0]   prev;
    logic [31:0]   back;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   tw;
    logic [31:0]   new_word;

    assign ks.busy      = busy_q;
    assign ks.ready_key = ready_q;
    assign ks.key_err   = err_q;
    assign ks.nr        = nr_q;
    assign ks.rd_valid  = rd_valid_q;
    assign ks.rd_key    = rd_key_q;

    always_comb begin
        load_nk = 4'd0;
        case (ks.key_len)
            2'd0:    load_nk = 4'd4;
            2'd1:    load_nk = 4'd6;
            2'd2:    load_nk = 4'd8;
            default: load_nk = 4'd0;
        endcase
    end

    assign len_ok = (load_nk != 4'd0) && (int'(load_nk) <= MAX_NK);
    assign load   = (state == IDLE) && ks.init_key && len_ok;

    // Next word from w[i-1] and w[i-Nk]; mod_cnt tracks i%Nk.
    assign prev   = mem[idx - AW'(1)];
    assign back   = mem[idx - AW'(nk)];
    assign sub_in = (mod_cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_sbox u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        tw = prev;
        if (mod_cnt == 3'd0)
            tw = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && mod_cnt == 3'd4)
            tw = sub_out;
    end

    assign new_word = back ^ tw;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load) begin
                for (int j = 0; j < MAX_NK; j++)
                    if (j < int'(load_nk)) mem[j] <= ks.key[255-32*j -: 32];
            end else if (state == EXPAND) begin
                mem[idx] <= new_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            last_idx <= '0;
            mod_cnt  <= '0;
            nk       <= '0;
            rcon     <= 8'h01;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            nr_q     <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ks.init_key) begin
                        if (len_ok) begin
                            nk       <= load_nk;
                            nr_q     <= load_nk + 4'd6;
                            idx      <= AW'(load_nk);
                            last_idx <= AW'(4 * (int'(load_nk) + 7) - 1);
                            mod_cnt  <= '0;
                            rcon     <= 8'h01;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                            state    <= EXPAND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    idx <= idx + AW'(1);
                    if ({1'b0, mod_cnt} == nk - 4'd1)
                        mod_cnt <= '0;
                    else
                        mod_cnt <= mod_cnt + 3'd1;
                    if (mod_cnt == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (idx == last_idx) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [AW-1:0] rd_base;
    logic          rd_hit;
    logic [127:0]  rd_raw;
    logic [127:0]  rd_word;

    assign rd_base = AW'({ks.rd_round, 2'b00});
    assign rd_hit  = (ks.rd_round <= nr_q);
    assign rd_raw  = {mem[rd_base], mem[rd_base + AW'(1)],
                      mem[rd_base + AW'(2)], mem[rd_base + AW'(3)]};

`ifdef AES_KEY_EQINV_EN
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] o;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            a[k]  = w[31-8*k -: 8];
            x2    = xt(a[k]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        for (int k = 0; k < 4; k++)
            o[31-8*k -: 8] = me[k] ^ mb[(k+1)%4] ^ md[(k+2)%4] ^ m9[(k+3)%4];
        return o;
    endfunction

    // Middle rounds only: round 0 and round nr stay in plain form.
    always_comb begin
        rd_word = rd_raw;
        if (ks.rd_inv && ks.rd_round != 4'd0 && ks.rd_round < nr_q)
            rd_word = {imc(rd_raw[127:96]), imc(rd_raw[95:64]),
                       imc(rd_raw[63:32]), imc(rd_raw[31:0])};
    end
`else
    logic unused_rd_inv;
    assign unused_rd_inv = ks.rd_inv;
    assign rd_word       = rd_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            rd_valid_q <= ks.rd_en;
            if (ks.rd_en) rd_key_q <= rd_hit ? rd_word : '0;
        end
    end
endmodule
